// File: rtl/fetch_pkg.sv
// Shared fetch-stage types and constants, imported by fetch, control and hazard logic.
package fetch_pkg;

    localparam int unsigned DEF_XLEN = 32;
    localparam int unsigned INSTR_W  = 32;
    localparam int unsigned CNT_W    = 32;

    localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        PC_PLUS4  = 2'b00,
        PC_TARGET = 2'b01,
        PC_RSVD   = 2'b10,
        PC_JALR   = 2'b11
    } pcsrc_t;

    // Taken control transfer: branch/jal or jalr target selected.
    function automatic logic is_redirect(input pcsrc_t src);
        return (src == PC_TARGET) || (src == PC_JALR);
    endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register; flush wins over stall, stall wins over load.
module if_id_reg
    import fetch_pkg::*;
#(
    parameter int unsigned XLEN = DEF_XLEN
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               stall,
    input  logic               flush,
    input  logic [INSTR_W-1:0] instr,
    input  logic [XLEN-1:0]    pc,
    input  logic [XLEN-1:0]    pc_plus4,
    output logic [INSTR_W-1:0] instr_d,
    output logic [XLEN-1:0]    pc_d,
    output logic [XLEN-1:0]    pc_plus4_d,
    output logic               valid_d
);

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            instr_d    <= NOP_INSTR;
            pc_d       <= '0;
            pc_plus4_d <= '0;
            valid_d    <= 1'b0;
        end else if (!stall) begin
            instr_d    <= instr;
            pc_d       <= pc;
            pc_plus4_d <= pc_plus4;
            valid_d    <= 1'b1;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// RV32I instruction-fetch stage: PC register, next-PC select and IF/ID register.
// Define FETCH_PERF_CNT_EN to build the fetch/redirect performance counters.
module fetch_stage
    import fetch_pkg::*;
#(
    parameter int unsigned     XLEN     = DEF_XLEN,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [1:0]         pcsrc_e,
    input  logic [XLEN-1:0]    pc_target_e,
    input  logic [XLEN-1:0]    alu_result_e,
    input  logic               stall_f,
    input  logic               stall_d,
    input  logic               flush_d,
    output logic [XLEN-1:0]    imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic [INSTR_W-1:0] instr_d,
    output logic [XLEN-1:0]    pc_d,
    output logic [XLEN-1:0]    pc_plus4_d,
    output logic               valid_d,
    output logic [CNT_W-1:0]   fetch_cnt,
    output logic [CNT_W-1:0]   redirect_cnt
);

    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_plus4_c;
    logic [XLEN-1:0] pc_next_c;
    pcsrc_t          pcsrc_c;
    logic            redirect_c;

    assign pcsrc_c    = pcsrc_t'(pcsrc_e);
    assign redirect_c = is_redirect(pcsrc_c);
    assign pc_plus4_c = pc + XLEN'(4);

    // Next-PC mux; the reserved code falls through to sequential fetch.
    always_comb begin
        pc_next_c = pc_plus4_c;
        case (pcsrc_c)
            PC_TARGET: pc_next_c = pc_target_e;
            PC_JALR:   pc_next_c = {alu_result_e[XLEN-1:1], 1'b0};
            default:   pc_next_c = pc_plus4_c;
        endcase
    end

    // A redirect must land even while fetch is stalled, or the target is lost.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc <= RESET_PC;
        end else if (redirect_c || !stall_f) begin
            pc <= pc_next_c;
        end
    end

    assign imem_addr = pc;

    if_id_reg #(
        .XLEN(XLEN)
    ) u_if_id_reg (
        .clk       (clk),
        .rst       (rst),
        .stall     (stall_d),
        .flush     (flush_d),
        .instr     (imem_rdata),
        .pc        (pc),
        .pc_plus4  (pc_plus4_c),
        .instr_d   (instr_d),
        .pc_d      (pc_d),
        .pc_plus4_d(pc_plus4_d),
        .valid_d   (valid_d)
    );

`ifdef FETCH_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_cnt    <= '0;
            redirect_cnt <= '0;
        end else begin
            if (!flush_d && !stall_d) begin
                fetch_cnt <= fetch_cnt + CNT_W'(1);
            end
            if (redirect_c) begin
                redirect_cnt <= redirect_cnt + CNT_W'(1);
            end
        end
    end
`else
    assign fetch_cnt    = '0;
    assign redirect_cnt = '0;
`endif

endmodule
